// File: rtl/truth_table_sweep_pkg.sv
// rtl/truth_table_sweep_pkg.sv - shared types and helpers for the truth-table sweep engine
// Purpose: FSM state encoding, the largest supported input count and the row-count helper.
// Ports: none (package).
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_t;

    localparam int MAX_N = 8;

    // Number of rows in an n-input truth table.
    function automatic int tt_rows(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweep_if.sv
// rtl/truth_table_sweep_if.sv - row/value stream with valid/ready and the external response bit
// Purpose: groups the per-row handshake between the sweep engine and its consumer.
// Signals: row (N), s, out_valid driven by the engine; out_ready, dut_s driven by the consumer.
interface truth_table_sweep_if #(
    parameter int N = 3
);
    logic [N-1:0] row;
    logic         s;
    logic         out_valid;
    logic         out_ready;
    logic         dut_s;

    modport master (
        output row, s, out_valid,
        input  out_ready, dut_s
    );

    modport slave (
        input  row, s, out_valid,
        output out_ready, dut_s
    );
endinterface

// File: rtl/truth_table_sweep_row_counter.sv
// rtl/truth_table_sweep_row_counter.sv - N-bit row counter with clear, enable and last-row flag
// Purpose: steps through truth-table rows; stops at the last row instead of wrapping.
// Ports: clk, reset (sync, active-high), clear_i, en_i in; row_o (N), last_o out.
module tt_row_counter
    import tt_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [N-1:0] row_o,
    output logic         last_o
);
    localparam logic [N-1:0] LAST_ROW = N'(tt_rows(N) - 1);

    logic [N-1:0] row_q, row_d;

    // The last row is found by comparison so the counter never relies on wrap-around.
    assign last_o = (row_q == LAST_ROW);
    assign row_o  = row_q;

    always_comb begin
        row_d = row_q;
        if (clear_i) begin
            row_d = '0;
        end else if (en_i && !last_o) begin
            row_d = row_q + {{(N-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/truth_table_sweep.sv
// rtl/truth_table_sweep.sv - sequential truth-table engine for an N-input boolean function
// Purpose: walks rows 0..2^N-1, presents each row with its mask value over valid/ready, and in
//          check mode counts mismatches of the external response against the mask.
// Ports: clk, reset (sync, active-high); start, mode, mask (2^N) in; bus (row/s/out_valid out,
//        out_ready/dut_s in); busy, done, ones (N+1), errors (N+1), first_err (N), err_flag out.
module truth_table_sweep
    import tt_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [(1<<N)-1:0]   mask,
    truth_table_sweep_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [N:0]          ones,
    output logic [N:0]          errors,
    output logic [N-1:0]        first_err,
    output logic                err_flag
);
    localparam int ROWS = tt_rows(N);

    tt_state_t       state_q, state_d;
    logic [ROWS-1:0] mask_q, mask_d;
    logic            mode_q, mode_d;
    logic [N:0]      ones_q, ones_d;
    logic [N:0]      errors_q, errors_d;
    logic [N-1:0]    first_err_q, first_err_d;
    logic            err_flag_q, err_flag_d;

    logic            cnt_clear, cnt_en, last_row;
    logic [N-1:0]    row;
    logic            s_w, run_w, hs;

    tt_row_counter #(.N(N)) u_row_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .row_o   (row),
        .last_o  (last_row)
    );

    // s is looked up from registered mask and row, so it moves in the same cycle as row.
    assign run_w = (state_q == RUN);
    assign s_w   = run_w ? mask_q[row] : 1'b0;
    assign hs    = run_w && bus.out_ready;

    assign bus.row       = row;
    assign bus.s         = s_w;
    assign bus.out_valid = run_w;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign ones          = ones_q;
    assign errors        = errors_q;
    assign first_err     = first_err_q;
    assign err_flag      = err_flag_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        ones_d      = ones_q;
        errors_d    = errors_q;
        first_err_d = first_err_q;
        err_flag_d  = err_flag_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    mask_d      = mask;
                    mode_d      = mode;
                    ones_d      = '0;
                    errors_d    = '0;
                    first_err_d = '0;
                    err_flag_d  = 1'b0;
                    cnt_clear   = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    cnt_en = 1'b1;
                    ones_d = ones_q + {{N{1'b0}}, s_w};
                    if (mode_q && (bus.dut_s != s_w)) begin
                        errors_d = errors_q + {{N{1'b0}}, 1'b1};
                        if (!err_flag_q) begin
                            first_err_d = row;
                            err_flag_d  = 1'b1;
                        end
                    end
                    if (last_row) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            ones_q      <= '0;
            errors_q    <= '0;
            first_err_q <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            ones_q      <= ones_d;
            errors_q    <= errors_d;
            first_err_q <= first_err_d;
            err_flag_q  <= err_flag_d;
        end
    end
endmodule

// File: tb/tb_truth_table_sweep.sv
// tb/tb_truth_table_sweep.sv - scoreboard bench for truth_table_sweep at N=3, N=1 and N=8
// Purpose: drives sweeps, predicts rows and results from the mask/force rules, checks in a monitor.
// Ports: none (top-level bench).
module tb_truth_table_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc;

    // N = 3 instance
    truth_table_sweep_if #(.N(3)) if3 ();
    logic       start3, mode3, busy3, done3, err_flag3;
    logic [7:0] mask3;
    logic [3:0] ones3, errors3;
    logic [2:0] first_err3;

    truth_table_sweep #(.N(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .mode(mode3), .mask(mask3), .bus(if3),
        .busy(busy3), .done(done3), .ones(ones3), .errors(errors3), .first_err(first_err3),
        .err_flag(err_flag3)
    );

    // N = 1 instance
    truth_table_sweep_if #(.N(1)) if1 ();
    logic       start1, busy1, done1, err_flag1;
    logic [1:0] mask1, ones1, errors1;
    logic [0:0] first_err1;
    int         n1_idx;

    truth_table_sweep #(.N(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .mode(1'b0), .mask(mask1), .bus(if1),
        .busy(busy1), .done(done1), .ones(ones1), .errors(errors1), .first_err(first_err1),
        .err_flag(err_flag1)
    );

    // N = 8 instance
    truth_table_sweep_if #(.N(8)) if8 ();
    logic         start8, busy8, done8, err_flag8;
    logic [255:0] mask8;
    logic [8:0]   ones8, errors8;
    logic [7:0]   first_err8;
    int           n8_idx;

    truth_table_sweep #(.N(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .mode(1'b0), .mask(mask8), .bus(if8),
        .busy(busy8), .done(done8), .ones(ones8), .errors(errors8), .first_err(first_err8),
        .err_flag(err_flag8)
    );

    typedef struct {
        logic [2:0] row;
        logic       s;
    } row_t;

    typedef struct {
        logic [3:0] ones;
        logic [3:0] errors;
        logic [2:0] first_err;
        logic       err_flag;
    } res_t;

    row_t exp_q[$];
    res_t res_q[$];

    // External device model: answers mask[row] with the rows in cur_force inverted;
    // outside handshake cycles it answers noise, which the engine must ignore.
    logic [7:0] cur_mask, cur_force;
    logic       junk;
    always_comb if3.dut_s = if3.out_ready ? (cur_mask[if3.row] ^ cur_force[if3.row]) : junk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic fail_now(input string nm, input string got, input string want);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %s, expected %s", nm, got, want);
    endtask

    // Reference: rows appear in order 0..7 with s = mask[row]; ones is the popcount of the mask;
    // in check mode every forced row is a mismatch and the lowest forced row is the first one.
    function automatic void push_model(input logic [7:0] m, input logic md, input logic [7:0] f);
        res_t r;
        for (int i = 0; i < 8; i++) exp_q.push_back('{row: 3'(i), s: m[i]});
        r.ones      = 4'($countones(m));
        r.errors    = md ? 4'($countones(f)) : 4'd0;
        r.err_flag  = md && (f != 8'd0);
        r.first_err = 3'd0;
        if (md) for (int i = 7; i >= 0; i--) if (f[i]) r.first_err = 3'(i);
        res_q.push_back(r);
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_row"},       {29'd0, if3.row},   0);
        chk({tag, "_s"},         {31'd0, if3.s},     0);
        chk({tag, "_out_valid"}, {31'd0, if3.out_valid}, 0);
        chk({tag, "_busy"},      {31'd0, busy3},     0);
        chk({tag, "_done"},      {31'd0, done3},     0);
        chk({tag, "_ones"},      {28'd0, ones3},     0);
        chk({tag, "_errors"},    {28'd0, errors3},   0);
        chk({tag, "_first_err"}, {29'd0, first_err3}, 0);
        chk({tag, "_err_flag"},  {31'd0, err_flag3}, 0);
    endtask

    // rmode: 0 ready always, 1 stall 3 cycles at row 4, 2 random ready,
    //        3 start poke at row 2 then reset at row 6.
    task automatic run_sweep(input logic [7:0] m, input logic md, input logic [7:0] f, input int rmode);
        int stalls;
        bit aborted;
        stalls    = 0;
        aborted   = 0;
        cur_mask  = m;
        cur_force = f;
        push_model(m, md, f);
        mask3 = m;
        mode3 = md;
        start3 = 1'b1;
        if3.out_ready = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        mask3  = ~m;
        mode3  = ~md;
        cyc = 1;
        while (!done3 && cyc < 200) begin
            junk = 1'($urandom_range(0, 1));
            if (rmode == 3 && if3.row == 3'd6) begin
                reset = 1'b1;
                @(posedge clk); #1;
                exp_q.delete();
                res_q.delete();
                check_zero("abort");
                reset = 1'b0;
                aborted = 1'b1;
                break;
            end
            start3 = (rmode == 3 && if3.row == 3'd2);
            case (rmode)
                1: begin
                    if (if3.row == 3'd4 && stalls < 3) begin
                        if3.out_ready = 1'b0;
                        stalls++;
                        chk("stall_s", {31'd0, if3.s}, {31'd0, m[4]});
                    end else begin
                        if3.out_ready = 1'b1;
                    end
                end
                2:       if3.out_ready = ($urandom_range(0, 3) != 0);
                default: if3.out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        start3 = 1'b0;
        if (!aborted) begin
            if (!done3) begin
                fail_now("n3_done_timeout", "no done", "done within 200 cycles");
            end else begin
                if (rmode == 0) chk("n3_done_cycle", cyc, 9);
                chk("n3_rows_left", exp_q.size(), 0);
                if3.out_ready = 1'b1;
                start3 = 1'b1;
                @(posedge clk); #1;
                start3 = 1'b0;
                chk("n3_busy_fall", {31'd0, busy3}, 0);
                chk("n3_ones_hold", {28'd0, ones3}, $countones(m));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start3 = 1'b0; mode3 = 1'b0; mask3 = 8'd0;
        start1 = 1'b0; mask1 = 2'b10;
        start8 = 1'b0; mask8 = '1;
        if3.out_ready = 1'b0;
        if1.out_ready = 1'b1; if1.dut_s = 1'b0;
        if8.out_ready = 1'b1; if8.dut_s = 1'b0;
        cur_mask = 8'd0; cur_force = 8'd0; junk = 1'b0;
        n1_idx = 0; n8_idx = 0;

        fork
            begin : mon3
                row_t e;
                res_t r;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        if (if3.out_valid && if3.out_ready) begin
                            if (exp_q.size() == 0) begin
                                fail_now("n3_extra_row", $sformatf("row %0d", if3.row), "no handshake");
                            end else begin
                                e = exp_q.pop_front();
                                chk("n3_row", {29'd0, if3.row}, {29'd0, e.row});
                                chk("n3_s",   {31'd0, if3.s},   {31'd0, e.s});
                            end
                        end
                        if (done3) begin
                            if (res_q.size() == 0) begin
                                fail_now("n3_extra_done", "done pulse", "no done");
                            end else begin
                                r = res_q.pop_front();
                                chk("n3_ones",      {28'd0, ones3},      {28'd0, r.ones});
                                chk("n3_errors",    {28'd0, errors3},    {28'd0, r.errors});
                                chk("n3_first_err", {29'd0, first_err3}, {29'd0, r.first_err});
                                chk("n3_err_flag",  {31'd0, err_flag3},  {31'd0, r.err_flag});
                            end
                        end
                    end
                end
            end
            begin : mon1
                forever begin
                    @(negedge clk);
                    if (!reset && if1.out_valid && if1.out_ready) begin
                        chk("n1_row", {31'd0, if1.row}, n1_idx);
                        chk("n1_s",   {31'd0, if1.s},   {31'd0, mask1[n1_idx]});
                        n1_idx++;
                    end
                end
            end
            begin : mon8
                forever begin
                    @(negedge clk);
                    if (!reset && if8.out_valid && if8.out_ready) begin
                        chk("n8_row", {24'd0, if8.row}, n8_idx);
                        chk("n8_s",   {31'd0, if8.s},   {31'd0, mask8[n8_idx]});
                        n8_idx++;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("reset");

        run_sweep(8'h51, 1'b0, 8'h00, 0);
        run_sweep(8'h51, 1'b0, 8'h00, 1);
        run_sweep(8'h51, 1'b1, 8'h20, 0);
        run_sweep(8'h51, 1'b1, 8'h60, 0);
        run_sweep(8'h51, 1'b1, 8'h02, 3);
        run_sweep(8'($urandom), 1'b1, 8'($urandom), 0);
        repeat (20) run_sweep(8'($urandom), 1'($urandom), 8'($urandom), 2);

        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (!done1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done1) begin
            fail_now("n1_done_timeout", "no done", "done within 20 cycles");
        end else begin
            chk("n1_done_cycle", cyc, 3);
            chk("n1_ones",       {30'd0, ones1}, 1);
            chk("n1_rows",       n1_idx, 2);
            chk("n1_last_row",   {31'd0, if1.row}, 1);
        end

        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done8) begin
            fail_now("n8_done_timeout", "no done", "done within 400 cycles");
        end else begin
            chk("n8_done_cycle", cyc, 257);
            chk("n8_ones",       {23'd0, ones8}, 256);
            chk("n8_rows",       n8_idx, 256);
            chk("n8_last_row",   {24'd0, if8.row}, 255);
            chk("n8_errors",     {23'd0, errors8}, 0);
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/truth_table_sweep.md
# truth_table_sweep

Parametrised sequential truth-table engine for N-input boolean functions. It walks every input row 0..2^N-1 in order. For each row it drives the row vector and the function value taken from a programmable minterm mask, using a valid/ready handshake. In check mode it compares an external device-under-test response against the mask and reports the mismatch count and the first failing row. It replaces hand-written per-row stimulus in the lab benches and generalises the fixed three-input expression blocks to any N.

## Interface
- N, default 3: number of function inputs; legal range 1..8.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- mode  in  1  0 = generate, 1 = check; captured on start.
- mask  in  2^N  minterm mask, bit i = f(row i); captured on start.
- dut_s  in  1  external response for the current row; sampled on handshake, used in check mode only.
- out_ready  in  1  consumer ready.
- row  out  N  current input combination; MSB = first variable.
- s  out  1  captured mask[row].
- out_valid  out  1  row/s valid.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at end of sweep.
- ones  out  N+1  count of rows with s=1 handshaken in the current sweep.
- errors  out  N+1  count of rows with dut_s != s in check mode.
- first_err  out  N  row of first mismatch; 0 if none.
- err_flag  out  1  at least one mismatch in the current sweep.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
  - Capture mask and mode.
  - Clear row, ones, errors, first_err and err_flag.
- RUN behaviour:
  - out_valid = 1; s = mask_q[row].
  - A handshake is out_valid & out_ready.
  - On each handshake: ones += s. If mode = 1 and dut_s != s, then errors += 1; if err_flag = 0, first_err <= row and err_flag <= 1.
  - Handshake with row != 2^N-1: row increments.
  - Handshake with row = 2^N-1: go to DONE. Detect the last row by compare, never by counter overflow. Row stays at 2^N-1.
- DONE: done = 1, out_valid = 0; unconditionally -> IDLE.
- Result registers hold until the next accepted start.
- In generate mode, errors, first_err and err_flag stay 0.
- start in RUN or DONE is ignored; no restart, no queuing.
- out_ready low in RUN: row, s and counters hold; no row is skipped or repeated.
- dut_s is ignored outside handshake cycles.
- Counter widths are N+1 so the value 2^N fits; no saturation is needed.

## Timing
- Reset values: row = 0, s = 0, out_valid = 0, busy = 0, done = 0, ones = 0, errors = 0, first_err = 0, err_flag = 0, state = IDLE.
- reset has priority over every other input.
- Reset mid-sweep: all outputs return to reset values at the next edge; no done pulse.
- Sweep timing:
  - start sampled at edge t: out_valid = 1 with row 0 after edge t.
  - Each handshake at edge k: next row presented after edge k.
  - Last handshake at edge k: done = 1 for the cycle after edge k; final ones/errors are visible in that same cycle.
  - busy falls one edge later.
- Minimum sweep (out_ready tied 1): 2^N cycles of out_valid, then 1 done cycle. Next start is accepted the cycle after done.
- s is a registered mask lookup driven from row with no added latency; row and s change together.

## Structure
- Shared package tt_pkg holds:
  - state enum tt_state_t {IDLE, RUN, DONE};
  - constant MAX_N = 8;
  - function tt_rows(n) returning 2^n.
- One natural sub-module, tt_row_counter: N-bit counter with enable, clear and last-row flag.
- FSM, mask register and accumulators live in the top module.

## Test plan
- N=3, mask=8'h51, mode=0, out_ready=1, start pulse:
  - rows 0..7 in consecutive cycles with s = 1,0,0,0,1,0,1,0;
  - done on cycle 9 after start;
  - ones = 3, errors = 0.
- Same sweep with out_ready low for 3 cycles at row 4: row 4 with s=1 held stable, then rows 5..7 follow; ones = 3, no row skipped.
- N=3, mask=8'h51, mode=1, dut_s = mask[row] except row 5 forced to 1: errors = 1, first_err = 5, err_flag = 1. Then row 6 forced 0 as well: errors = 2, first_err stays 5.
- start asserted at row 2 mid-sweep, then reset asserted at row 6:
  - the start is ignored;
  - the reset returns all outputs to 0 next edge, with no done pulse;
  - a later start runs a full, clean sweep.
- N=1, mask=2'b10: rows 0,1 with s = 0,1; ones = 1. N=8, mask = all ones: 256 rows, ones = 256 (9'h100), row ends at 8'hFF.
